// File: rtl/if_stage.sv
// if_stage: instruction fetch producer for the IF/ID interface (req/rsp imem, in-order FIFO).
// Define IF_PERF_EN to add the IF_perf_fetched / IF_perf_bubble counters.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        Imem_req_vld,
  output logic [31:0] Imem_req_addr,
  input  logic        Imem_req_rdy,
  input  logic        Imem_rsp_vld,
  input  logic [31:0] Imem_rsp_data,
  input  logic        ID_stall,
  input  logic        EX_redirect,
  input  logic [31:0] EX_redirect_pc,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_inst,
  output logic        IF_ID_vld
`ifdef IF_PERF_EN
  ,
  output logic [31:0] IF_perf_fetched,
  output logic [31:0] IF_perf_bubble
`endif
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  state_t                  state, state_n;
  logic [31:0]             fetch_pc, fetch_pc_n;
  logic [31:0]             slot_pc   [FIFO_DEPTH];
  logic [31:0]             slot_inst [FIFO_DEPTH];
  logic [31:0]             pc_n      [FIFO_DEPTH];
  logic [31:0]             inst_n    [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   slot_filled, filled_n;
  logic [PW-1:0]           head, tail, fill_ptr;
  logic [PW-1:0]           head_n, tail_n, fill_ptr_n;
  logic [CW-1:0]           occ, unfilled, stale;
  logic [CW-1:0]           occ_n, unfilled_n, stale_n;
  logic                    alloc, fill, drop, pop;

  assign Imem_req_vld  = (state == RUN) && (occ < DEPTH_C) && !EX_redirect;
  assign Imem_req_addr = fetch_pc;
  assign IF_ID_vld     = slot_filled[head] && !EX_redirect;

  always_comb begin
    alloc      = Imem_req_vld && Imem_req_rdy;
    fill       = Imem_rsp_vld && (state != FLUSH);
    drop       = Imem_rsp_vld && (state == FLUSH);
    pop        = IF_ID_vld && !ID_stall;
    state_n    = state;
    fetch_pc_n = fetch_pc;
    pc_n       = slot_pc;
    inst_n     = slot_inst;
    filled_n   = slot_filled;
    head_n     = head;
    tail_n     = tail;
    fill_ptr_n = fill_ptr;
    occ_n      = occ;
    unfilled_n = unfilled;
    stale_n    = stale;

    if (EX_redirect) begin
      // Outstanding requests become stale; a response landing this cycle retires one of them.
      filled_n   = '0;
      head_n     = '0;
      tail_n     = '0;
      fill_ptr_n = '0;
      occ_n      = '0;
      unfilled_n = '0;
      stale_n    = stale + unfilled - CW'(fill) - CW'(drop);
      fetch_pc_n = EX_redirect_pc & 32'hFFFF_FFFC;
      state_n    = (stale_n != '0) ? FLUSH : RUN;
    end else begin
      if (alloc) begin
        pc_n[tail]     = fetch_pc;
        filled_n[tail] = 1'b0;
        tail_n         = tail + PW'(1);
        fetch_pc_n     = fetch_pc + 32'd4;
      end
      // Fill after alloc so a same-cycle response can land in the slot just allocated.
      if (fill) begin
        inst_n[fill_ptr]   = Imem_rsp_data;
        filled_n[fill_ptr] = 1'b1;
        fill_ptr_n         = fill_ptr + PW'(1);
      end
      if (pop) begin
        filled_n[head] = 1'b0;
        head_n         = head + PW'(1);
      end
      occ_n      = occ + CW'(alloc) - CW'(pop);
      unfilled_n = unfilled + CW'(alloc) - CW'(fill);
      if (drop) stale_n = stale - CW'(1);
      case (state)
        BOOT:    state_n = RUN;
        FLUSH:   if (stale_n == '0) state_n = RUN;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      slot_pc     <= '{default: '0};
      slot_inst   <= '{default: '0};
      slot_filled <= '0;
      head        <= '0;
      tail        <= '0;
      fill_ptr    <= '0;
      occ         <= '0;
      unfilled    <= '0;
      stale       <= '0;
      IF_ID_pc    <= '0;
      IF_ID_inst  <= '0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      slot_pc     <= pc_n;
      slot_inst   <= inst_n;
      slot_filled <= filled_n;
      head        <= head_n;
      tail        <= tail_n;
      fill_ptr    <= fill_ptr_n;
      occ         <= occ_n;
      unfilled    <= unfilled_n;
      stale       <= stale_n;
      // Presentation registers only follow a filled head, so they hold across bubbles.
      if (filled_n[head_n]) begin
        IF_ID_pc   <= pc_n[head_n];
        IF_ID_inst <= inst_n[head_n];
      end
    end
  end

`ifdef IF_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      IF_perf_fetched <= '0;
      IF_perf_bubble  <= '0;
    end else begin
      if (pop) IF_perf_fetched <= IF_perf_fetched + 32'd1;
      if ((state == RUN) && !IF_ID_vld && !EX_redirect) IF_perf_bubble <= IF_perf_bubble + 32'd1;
    end
  end
`endif

endmodule
